// File: rtl/ppu_row_scheduler.sv
// ppu_row_scheduler
// Per-scanline sequencer for the PPU row-preparation datapath. A frame or
// line start selects the row to prepare, the enabled engines (BG, FG, sprite)
// are sent one-cycle prep pulses and their done flags are collected. When all
// enabled stages are complete, row_ready tells the pixel mixer the row
// buffers hold next_row.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   frame_start, line_start         start pulses (row 0 / next row)
//   bg_enable, fg_enable,
//   spr_enable                      layer enables; a disabled stage is skipped
//   bgte_done, fgte_done, spr_done  engine done levels
//   bgte_prep, fgte_prep, spr_prep  one-cycle prep pulses to the engines
//   next_row                        row index presented to all engines
//   busy                            a preparation sequence is in progress
//   row_ready                       all enabled stages done for next_row
//   overrun                         pulse: start arrived while busy
//   timeout                         pulse: an engine exceeded the wait limit
//
// SERIAL=1 preps the engines one after another because they share pattern
// RAM. SERIAL=0 preps every enabled engine in PREP_BG and collects all done
// flags in WAIT_BG using sticky per-engine latches.
module ppu_row_scheduler #(
    parameter int NUM_ROWS = 240,
    parameter int ROW_W    = 8,
    parameter int SERIAL   = 1,
    parameter int TIMEOUT  = 1500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             line_start,
    input  logic             bg_enable,
    input  logic             fg_enable,
    input  logic             spr_enable,
    input  logic             bgte_done,
    input  logic             fgte_done,
    input  logic             spr_done,
    output logic             bgte_prep,
    output logic             fgte_prep,
    output logic             spr_prep,
    output logic [ROW_W-1:0] next_row,
    output logic             busy,
    output logic             row_ready,
    output logic             overrun,
    output logic             timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREP_BG  = 3'd1,
        WAIT_BG  = 3'd2,
        PREP_FG  = 3'd3,
        WAIT_FG  = 3'd4,
        PREP_SPR = 3'd5,
        WAIT_SPR = 3'd6,
        READY    = 3'd7
    } state_t;

    // First enabled serial stage in BG, FG, SPR order; READY if none is left.
    function automatic state_t pick_stage(input logic bg, input logic fg, input logic spr);
        state_t st;
        if (bg) begin
            st = PREP_BG;
        end else if (fg) begin
            st = PREP_FG;
        end else if (spr) begin
            st = PREP_SPR;
        end else begin
            st = READY;
        end
        return st;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [2:0]       lat_q, lat_d;     // parallel mode: sticky done per engine
    logic [2:0]       en_q, en_d;       // parallel mode: enables captured at start
    logic [2:0]       prep_q, prep_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             ovr_q, ovr_d;
    logic             to_q, to_d;

    logic             start_s;
    logic [2:0]       en_s;
    logic [2:0]       done_s;
    logic             in_wait_s;
    logic             hit_s;
    state_t           exit_st_s;

    assign start_s = frame_start | line_start;
    assign en_s    = {spr_enable, fg_enable, bg_enable};
    assign done_s  = {spr_done, fgte_done, bgte_done};

    // Next state, wait counter, row selection and pulse flags.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        lat_d     = lat_q;
        en_d      = en_q;
        ovr_d     = 1'b0;
        to_d      = 1'b0;
        in_wait_s = 1'b0;
        hit_s     = 1'b0;
        exit_st_s = state_q;

        if (start_s) begin
            // A start in any state abandons the current sequence.
            ovr_d = busy_q;
            if (frame_start) begin
                row_d = ROW_ZERO;
            end else if (row_q == ROW_LAST) begin
                row_d = ROW_ZERO;
            end else begin
                row_d = row_q + ROW_ONE;
            end
            cnt_d = CNT_ZERO;
            en_d  = en_s;
            lat_d = ~en_s;
            if (SERIAL != 0) begin
                state_d = pick_stage(en_s[0], en_s[1], en_s[2]);
            end else if (|en_s) begin
                state_d = PREP_BG;
            end else begin
                state_d = READY;
            end
        end else begin
            case (state_q)
                PREP_BG: begin
                    state_d = WAIT_BG;
                    cnt_d   = CNT_ZERO;
                end
                PREP_FG: begin
                    state_d = WAIT_FG;
                    cnt_d   = CNT_ZERO;
                end
                PREP_SPR: begin
                    state_d = WAIT_SPR;
                    cnt_d   = CNT_ZERO;
                end
                WAIT_BG: begin
                    in_wait_s = 1'b1;
                    if (SERIAL != 0) begin
                        hit_s     = bgte_done;
                        exit_st_s = pick_stage(1'b0, fg_enable, spr_enable);
                    end else begin
                        hit_s     = &(lat_q | done_s);
                        exit_st_s = READY;
                    end
                end
                WAIT_FG: begin
                    in_wait_s = 1'b1;
                    hit_s     = fgte_done;
                    exit_st_s = pick_stage(1'b0, 1'b0, spr_enable);
                end
                WAIT_SPR: begin
                    in_wait_s = 1'b1;
                    hit_s     = spr_done;
                    exit_st_s = READY;
                end
                default: begin
                    state_d = state_q;
                end
            endcase

            // cnt_q == 0 marks the first wait cycle, where done is still the
            // previous row's value and must not be trusted.
            if (in_wait_s) begin
                if ((cnt_q != CNT_ZERO) && hit_s) begin
                    state_d = exit_st_s;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (cnt_q != CNT_ZERO) begin
                    lat_d = lat_q | done_s;
                end else begin
                    lat_d = lat_q;
                end
            end else begin
                cnt_d = cnt_d;
            end
        end
    end

    // Registered outputs derived from the state being entered.
    always_comb begin
        busy_d  = (state_d != IDLE) && (state_d != READY);
        ready_d = (state_d == READY);
        if (SERIAL != 0) begin
            prep_d = {state_d == PREP_SPR, state_d == PREP_FG, state_d == PREP_BG};
        end else if (state_d == PREP_BG) begin
            prep_d = en_d;
        end else begin
            prep_d = 3'b000;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            row_q   <= ROW_ZERO;
            lat_q   <= 3'b000;
            en_q    <= 3'b000;
            prep_q  <= 3'b000;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            lat_q   <= lat_d;
            en_q    <= en_d;
            prep_q  <= prep_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    assign bgte_prep = prep_q[0];
    assign fgte_prep = prep_q[1];
    assign spr_prep  = prep_q[2];
    assign next_row  = row_q;
    assign busy      = busy_q;
    assign row_ready = ready_q;
    assign overrun   = ovr_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_ppu_row_scheduler.sv
// Testbench for ppu_row_scheduler (SERIAL=1, TIMEOUT=20). Directed scenarios
// followed by randomized starts, enables and engine latencies, compared every
// cycle against a behavioural model that tracks the active stage and the
// cycles elapsed since its prep pulse.
module tb_ppu_row_scheduler;

    localparam int NUM_ROWS = 240;
    localparam int ROW_W    = 8;
    localparam int TIMEOUT  = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             frame_start, line_start;
    logic             bg_enable, fg_enable, spr_enable;
    logic             bgte_done, fgte_done, spr_done;
    logic             bgte_prep, fgte_prep, spr_prep;
    logic [ROW_W-1:0] next_row;
    logic             busy, row_ready, overrun, timeout;

    always #5 clk = ~clk;

    ppu_row_scheduler #(
        .NUM_ROWS(NUM_ROWS),
        .ROW_W   (ROW_W),
        .SERIAL  (1),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .line_start (line_start),
        .bg_enable  (bg_enable),
        .fg_enable  (fg_enable),
        .spr_enable (spr_enable),
        .bgte_done  (bgte_done),
        .fgte_done  (fgte_done),
        .spr_done   (spr_done),
        .bgte_prep  (bgte_prep),
        .fgte_prep  (fgte_prep),
        .spr_prep   (spr_prep),
        .next_row   (next_row),
        .busy       (busy),
        .row_ready  (row_ready),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int start_c;

    // reference model: row, active stage (0 BG, 1 FG, 2 SPR) and cycles since its prep
    int m_row, m_cur, m_since;
    bit m_active, m_ready, m_ovr, m_to;

    // engine models: done rises eng_lat cycles after prep (0 = never)
    int eng_age[3];
    int eng_lat[3];
    bit eng_armed[3];
    bit eng_stale[3];
    bit rand_lat;

    // event log
    int t_prep[3];
    int n_prep[3];
    int t_ready, n_ready_rise, n_ovr, n_to, t_to;
    bit ready_prev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic m_launch(input int after);
        logic [2:0] en;
        int nxt;
        en  = {spr_enable, fg_enable, bg_enable};
        nxt = -1;
        for (int k = 2; k > after; k--) begin
            if (en[k]) nxt = k;
        end
        if (nxt < 0) begin
            m_active = 1'b0;
            m_ready  = 1'b1;
        end else begin
            m_active = 1'b1;
            m_cur    = nxt;
            m_since  = 0;
        end
    endtask

    task automatic m_step();
        logic [2:0] dn;
        dn = {spr_done, fgte_done, bgte_done};
        if (!rst_n) begin
            m_row = 0; m_cur = 0; m_since = 0;
            m_active = 1'b0; m_ready = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
        end else begin
            m_ovr = 1'b0;
            m_to  = 1'b0;
            if (frame_start || line_start) begin
                m_ovr   = m_active;
                m_row   = frame_start ? 0 : (m_row + 1) % NUM_ROWS;
                m_ready = 1'b0;
                m_launch(-1);
            end else if (m_active) begin
                if (m_since == 0) begin
                    m_since = 1;
                end else if (m_since >= 2 && dn[m_cur]) begin
                    m_launch(m_cur);
                end else if (m_since == TIMEOUT) begin
                    m_to     = 1'b1;
                    m_active = 1'b0;
                end else begin
                    m_since++;
                end
            end
        end
    endtask

    task automatic eng_update();
        logic [2:0] pv;
        logic [2:0] dv;
        pv = {spr_prep, fgte_prep, bgte_prep};
        for (int i = 0; i < 3; i++) begin
            if (pv[i] === 1'b1) begin
                eng_armed[i] = 1'b1;
                eng_age[i]   = 0;
                if (rand_lat) begin
                    eng_lat[i]   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
                    eng_stale[i] = ($urandom_range(0, 3) == 0);
                end
            end else if (eng_armed[i] && eng_age[i] < 100000) begin
                eng_age[i]++;
            end
            dv[i] = eng_armed[i] && ((eng_lat[i] != 0 && eng_age[i] >= eng_lat[i]) ||
                                     (eng_stale[i] && eng_age[i] <= 1));
        end
        bgte_done = dv[0];
        fgte_done = dv[1];
        spr_done  = dv[2];
    endtask

    task automatic check_all();
        logic [2:0] pv;
        pv = {spr_prep, fgte_prep, bgte_prep};
        check_eq("next_row",  32'(next_row),  32'(m_row));
        check_eq("bgte_prep", 32'(bgte_prep), 32'(m_active && m_since == 0 && m_cur == 0));
        check_eq("fgte_prep", 32'(fgte_prep), 32'(m_active && m_since == 0 && m_cur == 1));
        check_eq("spr_prep",  32'(spr_prep),  32'(m_active && m_since == 0 && m_cur == 2));
        check_eq("busy",      32'(busy),      32'(m_active));
        check_eq("row_ready", 32'(row_ready), 32'(m_ready));
        check_eq("overrun",   32'(overrun),   32'(m_ovr));
        check_eq("timeout",   32'(timeout),   32'(m_to));
        for (int i = 0; i < 3; i++) begin
            if (pv[i] === 1'b1) begin
                if (n_prep[i] == 0) t_prep[i] = cyc;
                n_prep[i]++;
            end
        end
        if (row_ready === 1'b1 && !ready_prev) begin
            if (n_ready_rise == 0) t_ready = cyc;
            n_ready_rise++;
        end
        ready_prev = (row_ready === 1'b1);
        if (overrun === 1'b1) n_ovr++;
        if (timeout === 1'b1) begin
            if (n_to == 0) t_to = cyc;
            n_to++;
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < 3; i++) begin
            t_prep[i] = -1000;
            n_prep[i] = 0;
        end
        t_ready = -1000; n_ready_rise = 0; n_ovr = 0; n_to = 0; t_to = -1000;
        ready_prev = (row_ready === 1'b1);
    endtask

    // one clock: engines react, edge, model step, sample on the falling edge
    task automatic tick();
        eng_update();
        @(posedge clk);
        m_step();
        @(negedge clk);
        cyc++;
        frame_start = 1'b0;
        line_start  = 1'b0;
        check_all();
    endtask

    task automatic set_en(input logic bg, input logic fg, input logic spr);
        bg_enable = bg; fg_enable = fg; spr_enable = spr;
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; line_start = 1'b0;
        set_en(1'b1, 1'b1, 1'b1);
        bgte_done = 1'b0; fgte_done = 1'b0; spr_done = 1'b0;
        rand_lat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            eng_age[i] = 0; eng_lat[i] = 10; eng_armed[i] = 1'b0; eng_stale[i] = 1'b0;
        end
        m_row = 0; m_cur = 0; m_since = 0;
        m_active = 1'b0; m_ready = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
        @(negedge clk);
        clear_log();
        repeat (3) tick();
        check_eq("rst_row",   32'(next_row),  32'd0);
        check_eq("rst_busy",  32'(busy),      32'd0);
        check_eq("rst_ready", 32'(row_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // frame start, all engines done 10 cycles after prep
        clear_log();
        start_c = cyc; frame_start = 1'b1;
        repeat (45) tick();
        check_eq("t1_row",       32'(next_row),            32'd0);
        check_eq("t1_bg_delay",  32'(t_prep[0] - start_c), 32'd1);
        check_eq("t1_bg_fg",     32'(t_prep[1] - t_prep[0]), 32'd11);
        check_eq("t1_fg_spr",    32'(t_prep[2] - t_prep[1]), 32'd11);
        check_eq("t1_ready_lat", 32'(t_ready - start_c),   32'd34);
        for (int i = 0; i < 3; i++) check_eq("t1_prep_count", 32'(n_prep[i]), 32'd1);
        check_eq("t1_overrun",   32'(n_ovr), 32'd0);
        check_eq("t1_timeout",   32'(n_to),  32'd0);

        // all layers disabled: ready one cycle after start, row stepping and wrap
        set_en(1'b0, 1'b0, 1'b0);
        clear_log();
        start_c = cyc; frame_start = 1'b1;
        tick();
        check_eq("t2_ready_1cyc", 32'(row_ready), 32'd1);
        for (int r = 1; r <= NUM_ROWS; r++) begin
            line_start = 1'b1;
            tick();
            if (r == NUM_ROWS - 1) check_eq("t2_row_last", 32'(next_row), 32'd239);
        end
        check_eq("t2_row_wrap", 32'(next_row), 32'd0);
        check_eq("t2_no_preps", 32'(n_prep[0] + n_prep[1] + n_prep[2]), 32'd0);
        repeat (57) begin
            line_start = 1'b1;
            tick();
        end
        check_eq("t2_row57", 32'(next_row), 32'd57);
        frame_start = 1'b1; line_start = 1'b1;
        tick();
        check_eq("t2_both_start", 32'(next_row), 32'd0);

        // FG disabled: SPR follows BG directly
        set_en(1'b1, 1'b0, 1'b1);
        clear_log();
        start_c = cyc; line_start = 1'b1;
        repeat (40) tick();
        check_eq("t3_no_fg",     32'(n_prep[1]), 32'd0);
        check_eq("t3_bg_spr",    32'(t_prep[2] - t_prep[0]), 32'd11);
        check_eq("t3_ready_lat", 32'(t_ready - start_c), 32'd23);

        // BG done still high from the previous row during the first wait cycle
        set_en(1'b1, 1'b1, 1'b1);
        eng_stale[0] = 1'b1;
        clear_log();
        line_start = 1'b1;
        repeat (45) tick();
        check_eq("t4_stale_bg_fg", 32'(t_prep[1] - t_prep[0]), 32'd11);
        eng_stale[0] = 1'b0;

        // line start during WAIT_FG
        clear_log();
        start_c = cyc; line_start = 1'b1;
        repeat (15) tick();
        line_start = 1'b1;
        repeat (45) tick();
        check_eq("t5_overrun",  32'(n_ovr),        32'd1);
        check_eq("t5_bg_twice", 32'(n_prep[0]),    32'd2);
        check_eq("t5_ready_1",  32'(n_ready_rise), 32'd1);
        check_eq("t5_row",      32'(next_row),     32'd4);

        // sprite engine never finishes
        eng_lat[2] = 0;
        clear_log();
        line_start = 1'b1;
        repeat (60) tick();
        check_eq("t6_timeout_n",   32'(n_to), 32'd1);
        check_eq("t6_timeout_lat", 32'(t_to - t_prep[2]), 32'd21);
        check_eq("t6_busy",        32'(busy), 32'd0);
        check_eq("t6_ready",       32'(n_ready_rise), 32'd0);
        eng_lat[2] = 10;
        clear_log();
        line_start = 1'b1;
        repeat (45) tick();
        check_eq("t6_recover_ready", 32'(row_ready), 32'd1);
        check_eq("t6_recover_row",   32'(next_row),  32'd6);

        // reset while waiting for BG
        clear_log();
        line_start = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check_eq("t7_rst_row",  32'(next_row), 32'd0);
        check_eq("t7_rst_busy", 32'(busy),     32'd0);
        check_eq("t7_rst_prep", 32'({spr_prep, fgte_prep, bgte_prep}), 32'd0);
        rst_n = 1'b1;
        tick();

        // randomized traffic
        rand_lat = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            int k;
            if ($urandom_range(0, 29) == 0) begin
                k = int'($urandom_range(0, 7));
                if (k == 0) begin
                    frame_start = 1'b1; line_start = 1'b1;
                end else if (k < 3) begin
                    frame_start = 1'b1;
                end else begin
                    line_start = 1'b1;
                end
            end
            if ($urandom_range(0, 39) == 0) bg_enable  = ~bg_enable;
            if ($urandom_range(0, 39) == 0) fg_enable  = ~fg_enable;
            if ($urandom_range(0, 39) == 0) spr_enable = ~spr_enable;
            rst_n = ($urandom_range(0, 1499) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
